// File: rtl/reply_pkt_pkg.sv
// reply_pkt_pkg: shared word/K-flag constants and FSM state type for the reply packet sender
package reply_pkt_pkg;
  localparam logic [15:0] COMMA = 16'hBC3C;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [3:0] DCSReplyK = 4'h4;
  localparam logic [3:0] DataHeaderK = 4'h5;
  localparam logic [1:0] KCHAR = 2'b11;
  localparam logic [1:0] KCMD = 2'b10;
  localparam logic [1:0] KWORD = 2'b00;
  typedef enum logic [1:0] {IDLE, START, PAYLOAD, CRC} state_t;
endpackage

// File: rtl/crc16_ccitt_step.sv
// crc16_ccitt_step: folds one 16-bit word, MSB first, into a CRC-16-CCITT (poly 0x1021)
module crc16_ccitt_step (
  input  logic [15:0] crc_in,
  input  logic [15:0] word,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 15; i >= 0; i--)
      crc_out = {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ word[i]) ? 16'h1021 : 16'h0000);
  end
endmodule

// File: rtl/dcs_reply_pkt_sender.sv
// dcs_reply_pkt_sender: DCSReply / Data Header packet builder onto a 16-bit + K-flag TX stream.
// REPLY_CRC_EN appends a CRC-16-CCITT word over the payload.
module dcs_reply_pkt_sender
  import reply_pkt_pkg::*;
#(
  parameter logic [3:0] ROC_ID = 4'h0,
  parameter int PAYLOAD_WORDS = 8,
  parameter int MIN_IDLE = 1
) (
  input  logic        TX_CLK,
  input  logic        TX_RESET,
  input  logic        dcs_valid,
  output logic        dcs_ready,
  input  logic [15:0] dcs_addr,
  input  logic [15:0] dcs_data,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [15:0] hdr_pkt_cnt,
  input  logic [31:0] hdr_win_tag,
  output logic [15:0] data_out,
  output logic [1:0]  kchar_out,
  output logic        busy,
  output logic        pkt_done
);
  state_t state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [15:0] gap, gap_d;
  logic rdy, is_dcs, take_dcs, take_hdr, take, last, done_d;
  logic [15:0] addr, data, pkt_cnt, pay_d, data_d, crc_word;
  logic [31:0] win_tag;
  logic [1:0] k_d;
`ifdef REPLY_CRC_EN
  localparam state_t AFTER_PAY = CRC;
`else
  localparam state_t AFTER_PAY = IDLE;
`endif
  assign dcs_ready = rdy;
  assign hdr_ready = rdy & ~dcs_valid;
  assign take_dcs = dcs_valid & dcs_ready;
  assign take_hdr = hdr_valid & hdr_ready;
  assign take = take_dcs | take_hdr;
  assign last = cnt == 8'(PAYLOAD_WORDS - 1);
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      IDLE: state_d = take ? START : IDLE;
      START: begin
        state_d = PAYLOAD;
        cnt_d = '0;
      end
      PAYLOAD: begin
        state_d = last ? AFTER_PAY : PAYLOAD;
        cnt_d = last ? cnt : cnt + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // payload word for the counter value about to be shown; is_dcs is stable by then
  always_comb begin
    pay_d = cnt_d == 8'd0 ? {1'b1, 3'b0, ROC_ID, is_dcs ? DCSReplyK : DataHeaderK, 4'h0} :
            cnt_d == 8'd1 ? (is_dcs ? 16'h0000 : pkt_cnt) :
            cnt_d == 8'd2 ? (is_dcs ? addr : win_tag[15:0]) :
            cnt_d == 8'd3 ? (is_dcs ? data : win_tag[31:16]) : 16'h0000;
    data_d = state_d == IDLE    ? COMMA :
             state_d == START   ? {K28_0, 4'h0, take_dcs ? DCSReplyK : DataHeaderK} :
             state_d == PAYLOAD ? pay_d : crc_word;
    k_d = state_d == IDLE ? KCHAR : state_d == START ? KCMD : KWORD;
    gap_d = take ? 16'd0 :
            state_d != IDLE ? gap :
            gap >= 16'(MIN_IDLE) ? gap : gap + 16'd1;
  end
`ifdef REPLY_CRC_EN
  logic [15:0] crc, crc_next;
  crc16_ccitt_step u_crc (.crc_in(crc), .word(pay_d), .crc_out(crc_next));
  always_ff @(posedge TX_CLK)
    if (TX_RESET || take) crc <= 16'hFFFF;
    else if (state_d == PAYLOAD) crc <= crc_next;
  assign crc_word = crc;
  assign done_d = state_d == CRC;
`else
  assign crc_word = 16'h0000;
  assign done_d = state_d == PAYLOAD && cnt_d == 8'(PAYLOAD_WORDS - 1);
`endif
  always_ff @(posedge TX_CLK)
    if (TX_RESET) begin
      state <= IDLE;
      cnt <= '0;
      gap <= 16'(MIN_IDLE);
      rdy <= 1'b0;
      data_out <= COMMA;
      kchar_out <= KCHAR;
      busy <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      gap <= gap_d;
      rdy <= state_d == IDLE && gap_d >= 16'(MIN_IDLE);
      data_out <= data_d;
      kchar_out <= k_d;
      busy <= state_d != IDLE;
      pkt_done <= done_d;
    end
  always_ff @(posedge TX_CLK)
    if (take) begin
      is_dcs <= take_dcs;
      addr <= dcs_addr;
      data <= dcs_data;
      pkt_cnt <= hdr_pkt_cnt;
      win_tag <= hdr_win_tag;
    end
endmodule

// File: tb/tb_dcs_reply_pkt_sender.sv
// tb_dcs_reply_pkt_sender: directed + random packets checked against a word-list reference model
module tb_dcs_reply_pkt_sender;
  localparam logic [3:0] ROC = 4'h3;
  localparam int N = 8;
  localparam int GAP = 2;
  logic clk = 0, rst = 1;
  logic dcs_valid = 0, hdr_valid = 0, dcs_ready, hdr_ready, busy, pkt_done;
  logic [15:0] dcs_addr = 0, dcs_data = 0, hdr_pkt_cnt = 0, data_out;
  logic [31:0] hdr_win_tag = 0;
  logic [1:0] kchar_out;
  int total = 0, bad = 0;
  logic [17:0] exp_q[$];
  always #5 clk = ~clk;
  dcs_reply_pkt_sender #(.ROC_ID(ROC), .PAYLOAD_WORDS(N), .MIN_IDLE(GAP)) dut (
    .TX_CLK(clk), .TX_RESET(rst),
    .dcs_valid(dcs_valid), .dcs_ready(dcs_ready), .dcs_addr(dcs_addr), .dcs_data(dcs_data),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_pkt_cnt(hdr_pkt_cnt), .hdr_win_tag(hdr_win_tag),
    .data_out(data_out), .kchar_out(kchar_out), .busy(busy), .pkt_done(pkt_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // expected packet as {kchar, word} list: start word, payload, optional CRC
  task automatic build(input bit dcs, input logic [15:0] a, d, c, input logic [31:0] t);
    logic [15:0] f[3];
    logic [15:0] w;
    logic [15:0] crc;
    logic [3:0] ty;
    ty = dcs ? 4'h4 : 4'h5;
    crc = 16'hFFFF;
    if (dcs) begin f[0] = 16'h0000; f[1] = a; f[2] = d; end
    else begin f[0] = c; f[1] = t[15:0]; f[2] = t[31:16]; end
    exp_q.delete();
    exp_q.push_back({2'b10, 8'h1C, 4'h0, ty});
    for (int i = 0; i < N; i++) begin
      w = i == 0 ? {4'h8, ROC, ty, 4'h0} : i <= 3 ? f[i-1] : 16'h0000;
      exp_q.push_back({2'b00, w});
      for (int b = 15; b >= 0; b--) crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ w[b]) ? 16'h1021 : 16'h0000);
    end
`ifdef REPLY_CRC_EN
    exp_q.push_back({2'b00, crc});
`endif
  endtask
  task automatic check_pkt(input bit hdr_chk, input bit keep_hdr);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      chk("word", {14'd0, kchar_out, data_out}, {14'd0, exp_q[i]});
      chk("busy", busy, 1);
      chk("pkt_done", pkt_done, i == exp_q.size() - 1);
      if (hdr_chk) chk("hdr_ready_hold", hdr_ready, 0);
      if (i == 0) begin
        dcs_valid = 0;
        dcs_addr = 16'($urandom);
        dcs_data = 16'($urandom);
        if (!keep_hdr) begin
          hdr_valid = 0;
          hdr_pkt_cnt = 16'($urandom);
          hdr_win_tag = $urandom;
        end
      end
    end
  endtask
  task automatic wait_ready(input bit dcs);
    int n = 0;
    while (!(dcs ? dcs_ready : hdr_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(dcs ? "dcs_ready_wait" : "hdr_ready_wait", dcs ? dcs_ready : hdr_ready, 1);
  endtask
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_word", {14'd0, kchar_out, data_out}, {14'd0, 2'b11, 16'hBC3C});
      chk("idle_busy", busy, 0);
      chk("idle_done", pkt_done, 0);
    end
  endtask
  task automatic send(input bit dcs, input logic [15:0] a, d, c, input logic [31:0] t);
    dcs_valid = dcs;
    hdr_valid = !dcs;
    dcs_addr = a;
    dcs_data = d;
    hdr_pkt_cnt = c;
    hdr_win_tag = t;
    wait_ready(dcs);
    @(negedge clk);
    build(dcs, a, d, c, t);
    check_pkt(0, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      chk("rst_word", {14'd0, kchar_out, data_out}, {14'd0, 2'b11, 16'hBC3C});
      chk("rst_busy", busy, 0);
      chk("rst_done", pkt_done, 0);
      chk("rst_dcs_ready", dcs_ready, i >= 2);
      chk("rst_hdr_ready", hdr_ready, i >= 2);
    end
    send(1, 16'h0012, 16'hBEEF, 16'($urandom), $urandom);
    idle_check(3);
    send(0, 16'($urandom), 16'($urandom), 16'h0003, 32'h00ABCDEF);
    idle_check(2);
    dcs_valid = 1;
    hdr_valid = 1;
    dcs_addr = 16'h1234;
    dcs_data = 16'h5678;
    hdr_pkt_cnt = 16'h0042;
    hdr_win_tag = 32'hCAFE_F00D;
    wait_ready(1);
    @(negedge clk);
    build(1, 16'h1234, 16'h5678, 16'h0042, 32'hCAFE_F00D);
    check_pkt(1, 1);
    for (int j = 0; j < GAP; j++) begin
      @(negedge clk);
      chk("gap_word", {14'd0, kchar_out, data_out}, {14'd0, 2'b11, 16'hBC3C});
      chk("gap_busy", busy, 0);
    end
    @(negedge clk);
    build(0, 16'h1234, 16'h5678, 16'h0042, 32'hCAFE_F00D);
    check_pkt(0, 0);
    idle_check(2);
    dcs_valid = 1;
    dcs_addr = 16'h0777;
    dcs_data = 16'h8888;
    wait_ready(1);
    @(negedge clk);
    dcs_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_word", {14'd0, kchar_out, data_out}, {14'd0, 2'b11, 16'hBC3C});
    chk("abort_busy", busy, 0);
    chk("abort_done", pkt_done, 0);
    chk("abort_ready", dcs_ready, 0);
    rst = 0;
    idle_check(4);
    send(1, 16'h00A5, 16'h5A5A, 16'h0, 32'h0);
    idle_check(1);
    for (int r = 0; r < 8; r++) begin
      bit dcs;
      dcs = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(dcs, 16'($urandom), 16'($urandom), 16'($urandom), $urandom);
      idle_check(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
